// File: rtl/vp_ctrl_pkg.sv
// Shared widths, FSM state type and sizing helper for the vp mode controller.
package vp_ctrl_pkg;

  localparam int unsigned MODE_W      = 3;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } ctrl_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stability counter for the raw board switches.
module sw_debounce
  import vp_ctrl_pkg::*;
#(
  parameter int unsigned          DEBOUNCE_CYCLES = 1000000,
  parameter logic [MODE_W-1:0]    RESET_MODE      = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] sw_in,
  output logic [MODE_W-1:0] cand,
  output logic              stable
);

  localparam int unsigned        DCNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0]  DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic [MODE_W-1:0] sw_m;
  logic [MODE_W-1:0] sw_s;
  logic [DCNT_W-1:0] dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_m <= RESET_MODE;
      sw_s <= RESET_MODE;
      cand <= RESET_MODE;
      dcnt <= '0;
    end else begin
      sw_m <= sw_in;
      sw_s <= sw_m;
      if (sw_s != cand) begin
        cand <= sw_s;
        dcnt <= '0;
      end else if (dcnt != DCNT_MAX) begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign stable = (sw_s == cand) && (dcnt == DCNT_MAX);

endmodule

// File: rtl/vp_mode_ctrl.sv
// Frame-synchronous mode controller: applies debounced switch changes on
// v_sync rising edges, blanks output while the pipeline refills, counts frames.
module vp_mode_ctrl
  import vp_ctrl_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned       SETTLE_FRAMES   = 2,
  parameter logic [MODE_W-1:0] RESET_MODE      = 3'b000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MODE_W-1:0]      sw_in,
  input  logic                   v_sync_in,
  output logic [MODE_W-1:0]      sw_out,
  output logic                   mode_changed,
  output logic                   blank_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned       SCNT_W    = cnt_width(SETTLE_FRAMES + 1);
  localparam logic [SCNT_W-1:0] SCNT_INIT = SCNT_W'(SETTLE_FRAMES);

  ctrl_state_t       state, state_nxt;
  logic [MODE_W-1:0] cand;
  logic              stable;
  logic              vs_d;
  logic              fe;
  logic              want_change;
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic [MODE_W-1:0] sw_nxt;
  logic              mc_nxt;
  logic              blank_nxt;

  sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_MODE      (RESET_MODE)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .cand   (cand),
    .stable (stable)
  );

  assign fe          = v_sync_in & ~vs_d;
  assign want_change = stable && (cand != sw_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      sw_out       <= RESET_MODE;
      mode_changed <= 1'b0;
      blank_out    <= 1'b0;
      scnt         <= '0;
      vs_d         <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      sw_out       <= sw_nxt;
      mode_changed <= mc_nxt;
      blank_out    <= blank_nxt;
      scnt         <= scnt_nxt;
      vs_d         <= v_sync_in;
      if (fe) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Losing stability or matching sw_out drops PENDING even on a frame edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (want_change) state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (!want_change)  state_nxt = ST_IDLE;
        else if (fe)       state_nxt = (SETTLE_FRAMES == 0) ? ST_IDLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (fe && (scnt == SCNT_W'(1))) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sw_nxt    = sw_out;
    mc_nxt    = 1'b0;
    blank_nxt = blank_out;
    scnt_nxt  = scnt;
    unique case (state)
      ST_PENDING: begin
        if (want_change && fe) begin
          sw_nxt = cand;
          mc_nxt = 1'b1;
          if (SETTLE_FRAMES != 0) begin
            blank_nxt = 1'b1;
            scnt_nxt  = SCNT_INIT;
          end
        end
      end
      ST_SETTLE: begin
        if (fe) begin
          if (scnt == SCNT_W'(1)) blank_nxt = 1'b0;
          else                    scnt_nxt  = scnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vp_mode_ctrl.sv
// Randomised and directed bench for vp_mode_ctrl against a run-length/frame-count
// reference model; mode updates are scoreboarded and presented on mode_changed.
module tb_vp_mode_ctrl;
  import vp_ctrl_pkg::*;

  localparam int unsigned D      = 4;
  localparam int unsigned S      = 2;
  localparam int unsigned FRAME  = 20;
  localparam int unsigned VS_LEN = 3;
  localparam logic [2:0]  RM     = 3'b000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sw_in = 3'b000;
  logic        v_sync_in = 1'b0;
  logic [2:0]  sw_out;
  logic        mode_changed;
  logic        blank_out;
  logic [15:0] frame_cnt;

  vp_mode_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .SETTLE_FRAMES   (S),
    .RESET_MODE      (RM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_in        (sw_in),
    .v_sync_in    (v_sync_in),
    .sw_out       (sw_out),
    .mode_changed (mode_changed),
    .blank_out    (blank_out),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {
    logic [2:0]  mode;
    logic [15:0] fcnt;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic        m_valid = 1'b0;
  logic [2:0]  m_s1, m_s2, m_runval;
  int unsigned m_run;
  logic        m_prev_stab, m_vs_prev, m_prev_blank;
  logic [2:0]  m_out;
  logic        m_mc, m_blank;
  int unsigned m_frames;
  logic [15:0] m_fcnt;
  logic        skip_fc = 1'b0;
  logic        hold_vs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Frame timing: 20-cycle frames with a 3-cycle active-high v_sync pulse.
  initial begin
    int unsigned phase = 0;
    forever begin
      @(negedge clk);
      v_sync_in = hold_vs || (phase < VS_LEN);
      phase = (phase + 1) % FRAME;
    end
  end

  // Model: a switch value is accepted once sw_s has held it for D+1 samples;
  // a new accepted value is applied on a frame edge if it was already accepted
  // the cycle before and no blanking window is active.
  initial begin
    logic fe, stab, apply;
    logic [2:0] ss;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1 = RM; m_s2 = RM; m_runval = RM; m_run = 1;
        m_prev_stab = 1'b0; m_vs_prev = 1'b0; m_prev_blank = 1'b0;
        m_out = RM; m_mc = 1'b0; m_blank = 1'b0; m_frames = 0; m_fcnt = '0;
      end else begin
        fe    = v_sync_in && !m_vs_prev;
        stab  = (m_run >= D + 1);
        apply = fe && !m_blank && !m_prev_blank && stab && m_prev_stab && (m_runval != m_out);
        m_prev_blank = m_blank;
        m_prev_stab  = stab;
        m_mc = 1'b0;
        if (apply) begin
          m_out = m_runval;
          m_mc  = 1'b1;
          if (S > 0) begin
            m_blank  = 1'b1;
            m_frames = S;
          end
        end else if (m_blank && fe) begin
          m_frames--;
          if (m_frames == 0) m_blank = 1'b0;
        end
        if (fe) m_fcnt = m_fcnt + 16'd1;
        if (apply) sb.push_back('{mode: m_out, fcnt: m_fcnt});
        m_vs_prev = v_sync_in;
        ss   = m_s1;
        m_s1 = sw_in;
        m_s2 = ss;
        if (ss == m_runval) begin
          if (m_run < 1000) m_run++;
        end else begin
          m_runval = ss;
          m_run    = 1;
        end
      end
      m_valid = 1'b1;
    end
  end

  // Monitor: per-cycle output comparison plus scoreboard pop on mode_changed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("sw_out", sw_out, m_out);
        chk("blank_out", blank_out, m_blank);
        chk("mode_changed", mode_changed, m_mc);
        if (!skip_fc) chk("frame_cnt", frame_cnt, m_fcnt);
        if (mode_changed === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got mode_changed with sw_out=%0d, expected no update", sw_out);
          end else begin
            e = sb.pop_front();
            chk("sb_mode", sw_out, e.mode);
            chk("sb_fcnt", frame_cnt, e.fcnt);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] old;
    rst = 1'b1; sw_in = 3'b000;
    cyc(3);
    rst = 1'b0;
    cyc(3 * FRAME);

    // Short glitch: never accepted
    sw_in = 3'b101; cyc(3); sw_in = 3'b000; cyc(2 * FRAME);

    // Mid-frame change, applied at next frame edge, then 2-frame blank
    cyc(7); sw_in = 3'b010; cyc(4 * FRAME);

    // Change, then another change during SETTLE
    sw_in = 3'b001; cyc(FRAME + 5);
    sw_in = 3'b100; cyc(6 * FRAME);

    // Reset during SETTLE, switch still held
    sw_in = 3'b010; cyc(FRAME + 8);
    rst = 1'b1; cyc(1); rst = 1'b0;
    cyc(5 * FRAME);

    // Glitch that returns to the current mode while PENDING
    @(negedge v_sync_in); cyc(1);
    old = sw_in; sw_in = old ^ 3'b110; cyc(9); sw_in = old;
    cyc(2 * FRAME);

    // v_sync held high: a single frame edge
    hold_vs = 1'b1; sw_in = 3'b011; cyc(60);
    hold_vs = 1'b0; cyc(5 * FRAME);

    // Frame counter wrap with a simultaneous mode application
    @(negedge v_sync_in); cyc(1);
    skip_fc = 1'b1;
    @(posedge clk); #1 force dut.frame_cnt = 16'd65534;
    @(posedge clk); #1 release dut.frame_cnt;
    m_fcnt  = 16'd65534;
    skip_fc = 1'b0;
    sw_in   = m_out ^ 3'b101;
    cyc(5 * FRAME);

    // Randomised switch activity with occasional resets
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1; cyc($urandom_range(1, 2)); rst = 1'b0;
      end
      if ($urandom_range(0, 2) != 0) sw_in = 3'($urandom_range(0, 7));
      cyc($urandom_range(1, 45));
    end
    cyc(5 * FRAME);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
